// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller: FSM states,
// hex-to-segment table (segments {a,b,c,d,e,f,g}, active-high) and anode mask helper.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } state_t;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // All-anodes-off pattern for a given digit count, padded to MAX_DIGITS.
  function automatic logic [MAX_DIGITS-1:0] an_off_mask(input int digits);
    logic [MAX_DIGITS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to 7-segment decoder; zero latency, no flow control.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-seg scanner with frame-aligned double buffering; outputs registered, one cycle
// behind the FSM; load is always accepted (no backpressure). Option SEG7_LEADING_ZERO_BLANK_EN suppresses leading zeros.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  pending,
  output logic                  frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [MAX_DIGITS-1:0] AN_OFF_FULL = an_off_mask(DIGITS);
  localparam logic [DIGITS-1:0] AN_OFF = AN_OFF_FULL[DIGITS-1:0];
  // With no blanking, every slot starts directly in SHOW.
  localparam state_t SLOT_FIRST = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] disp_val, shadow_val;
  logic [DIGITS-1:0]   disp_dp, shadow_dp;

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic [6:0]          cur_seg;
  logic                cur_lit;
  logic [DIGITS-1:0]   an_show;
  logic                slot_end;
  logic                wrap;

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = disp_val[4*i +: 4];
        cur_dp  = disp_dp[i];
      end
    end
  end

  seg7_hex_dec u_dec (
    .hex (cur_nib),
    .seg (cur_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Walk from the top digit down; a digit is dark if it and everything above it is zero and its dp is off.
  always_comb begin
    upper_zero = 1'b1;
    cur_lit    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_val[4*i +: 4] == 4'h0);
      if ((idx == IW'(i)) && (i != 0) && upper_zero && !disp_dp[i]) cur_lit = 1'b0;
    end
  end
`else
  assign cur_lit = 1'b1;
`endif

  always_comb begin
    an_show = AN_OFF;
    for (int i = 0; i < DIGITS; i++) begin
      if ((idx == IW'(i)) && cur_lit) an_show[i] = 1'b0;
    end
  end

  assign slot_end = (cnt == CNT_LAST);
  assign wrap     = (state == ST_SHOW) && slot_end && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      idx        <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      an         <= AN_OFF;
      seg        <= 7'h00;
      dp         <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Output stage reflects the state held during this cycle.
      if (state == ST_SHOW) begin
        an  <= an_show;
        seg <= cur_seg;
        dp  <= cur_dp;
      end else begin
        an  <= AN_OFF;
        seg <= 7'h00;
        dp  <= 1'b0;
      end

      if (!enable) begin
        state <= ST_IDLE;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= SLOT_FIRST;
            cnt   <= '0;
            idx   <= '0;
          end
          ST_BLANK: begin
            if (cnt == BLANK_LAST) state <= ST_SHOW;
            cnt <= cnt + 1'b1;
          end
          ST_SHOW: begin
            if (slot_end) begin
              state <= SLOT_FIRST;
              cnt   <= '0;
              if (wrap) begin
                idx        <= '0;
                frame_done <= 1'b1;
                disp_val   <= shadow_val;
                disp_dp    <= shadow_dp;
                pending    <= 1'b0;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      // A load on the wrap cycle lands in the shadow and keeps pending set.
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp_in;
        pending    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It holds a hex value for `DIGITS` digits, sequences one digit at a time through a hex-to-segment decoder, and inserts a blanking gap between digits to suppress ghosting. New values are double-buffered and applied only at frame boundaries, so a frame never mixes old and new digits. It sits between the application datapath and the board's segment and anode pins.

## Interface
- `DIGITS`, 4: number of digits scanned (1–8).
- `REFRESH_DIV`, 50000: clock cycles per digit slot (≥ 2).
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off. Must be < `REFRESH_DIV`; 0 disables blanking.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: scanning runs while high.
- `load` in 1: single-cycle strobe that captures `value` and `dp_in` into the shadow register.
- `value` in 4·DIGITS: hex nibbles; digit 0 is `value[3:0]` (rightmost).
- `dp_in` in DIGITS: decimal point per digit, active-high.
- `seg` out 7: segments {a,b,c,d,e,f,g}, active-high, registered.
- `dp` out 1: decimal point, active-high, registered.
- `an` out DIGITS: digit anodes, active-low, registered.
- `pending` out 1: shadow holds data not yet displayed.
- `frame_done` out 1: one-cycle pulse after the last digit slot completes.

## Operation
- FSM states:
  - IDLE: `an` is all ones, and `seg`/`dp` are 0.
  - BLANK: `an` is all ones. The digit index is valid.
  - SHOW: `an[idx]`=0, and `seg`/`dp` show the digit at `idx`.
- IDLE→BLANK when `enable`=1. The slot counter and `idx` start at 0. If `BLANK_CYCLES`=0, go directly to SHOW.
- Slot counter `cnt` runs from 0 to `REFRESH_DIV`-1.
  - BLANK→SHOW when `cnt`=`BLANK_CYCLES`-1.
  - SHOW ends when `cnt`=`REFRESH_DIV`-1. The FSM then increments `idx`, clears `cnt`, and enters BLANK (or SHOW if there is no blanking).
- `idx` wraps from `DIGITS`-1 to 0. On the wrap cycle:
  - `frame_done` pulses.
  - The display register copies the shadow, and `pending` clears.
- `load`:
  - Shadow ← {`value`, `dp_in`}, and `pending`←1.
  - If `load` arrives again before the frame boundary, it overwrites the shadow; only the last value is shown.
- `load` on the wrap cycle: the display register takes the old shadow. The new data lands in the shadow, and `pending` stays 1 for the next frame.
- Decoder map:
  - 0→1111110, 1→0110000, 2→1101101, 3→1111001
  - 4→0110011, 5→1011011, 6→1011111, 7→1110000
  - 8→1111111, 9→1111011, A→1110111, b→0011111
  - C→1001110, d→0111101, E→1001111, F→1000111
- `enable` falling in any state: the FSM enters IDLE next cycle, and `cnt`/`idx` clear. The display register and shadow are retained.

## Timing
- Reset values:
  - `an`=all ones; `seg`=0; `dp`=0; `pending`=0; `frame_done`=0.
  - FSM=IDLE; `cnt`=0; `idx`=0.
  - Display register and shadow = 0.
- Outputs are registered and lag the FSM state by 1 cycle. With `enable` held high from reset release, the first anode goes low at cycle `BLANK_CYCLES`+1.
- A frame lasts `DIGITS`·`REFRESH_DIV` cycles. `frame_done` is high for exactly 1 cycle per frame.
- `load`→`pending` latency is 1 cycle. A load is displayed at most one frame plus 1 cycle later.
- `rst_n` assertion mid-frame forces all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN`:
  - When defined: any digit whose nibble and all higher nibbles are zero, and whose `dp` is 0, keeps its anode high during SHOW. Digit 0 is never suppressed.
  - When undefined: every digit is lit during its SHOW slot.

## Structure
- Package `seg7_pkg` holds:
  - The FSM state enum (IDLE, BLANK, SHOW).
  - The 16-entry segment constant table.
  - The anode-off constant width helper.
- Sub-module `seg7_hex_dec`: purely combinational 4-bit→7-bit decoder using the table above. It is instantiated once on the muxed nibble.

## Test plan
- Reset with `enable`=1, `DIGITS`=4, `REFRESH_DIV`=8, `BLANK_CYCLES`=2, no load → `an` cycles 1110, 1101, 1011, 0111 with 2 all-ones cycles before each, `seg`=1111110 for each digit, `frame_done` every 32 cycles.
- `load` with `value`=16'h1A3F, `dp_in`=4'b0100 mid-frame → `pending`=1 until the wrap. The next frame shows F, 3 (`dp`=0), A (`dp`=1), 1 as 1000111, 1111001, 1110111, 0110000.
- `load` on the exact `frame_done` cycle → the old value is shown for one more frame, `pending` stays 1, and the new value appears the frame after.
- `enable` dropped during a SHOW of digit 2 → next cycle the FSM is IDLE and `an`=1111 after 1 cycle. On re-enable, scanning restarts at digit 0 in BLANK.
- `rst_n` pulsed low mid-SHOW → `an`=1111 and `seg`=0 immediately. After release, the display register is 0.
- With `SEG7_LEADING_ZERO_BLANK_EN` and `value`=16'h0050 → digits 3 and 2 keep their anodes high, while digits 1 (5) and 0 (0) are lit.
